// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, encodings and helpers for the memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE = 2'b00,
        MEM_ARB_REQ  = 2'b01,
        MEM_ARB_WAIT = 2'b10
    } arb_state_t;

    localparam logic MEM_OWN_IM = 1'b0;
    localparam logic MEM_OWN_DM = 1'b1;

    localparam int STREAK_W = 4;

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } bus_req_t;

    // Only a DM win over a waiting fetch extends the streak; it saturates at all-ones.
    function automatic logic [STREAK_W-1:0] streak_next(input logic [STREAK_W-1:0] cur,
                                                        input logic im_waiting);
        logic [STREAK_W-1:0] nxt;
        nxt = '0;
        if (im_waiting) begin
            nxt = (cur == {STREAK_W{1'b1}}) ? cur : cur + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - DM-priority grant select with fetch anti-starvation streak counter.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic im_valid,
    input  logic dm_valid,
    input  logic accept,
    output logic grant_im,
    output logic grant_dm
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DM_STREAK);

    logic [STREAK_W-1:0] streak;
    logic                im_forced;

    assign im_forced = (streak == STREAK_LIMIT);

    always_comb begin
        grant_im = 1'b0;
        grant_dm = 1'b0;
        if (im_valid && (!dm_valid || im_forced)) begin
            grant_im = 1'b1;
        end else if (dm_valid) begin
            grant_dm = 1'b1;
        end
    end

    // Grants only become handshakes while the arbiter is idle, so count only then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (accept) begin
            if (grant_im) begin
                streak <= '0;
            end else if (grant_dm) begin
                streak <= streak_next(streak, im_valid);
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - non-pipelined fetch/data arbiter onto one memory bus.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] im_req_addr,
    input  logic        im_req_valid,
    output logic        im_req_ready,
    input  logic        im_flush,
    output logic [63:0] im_resp_rdata,
    output logic        im_resp_valid,
    input  logic [63:0] dm_req_addr,
    input  logic        dm_req_wen,
    input  logic [63:0] dm_req_wdata,
    input  logic [7:0]  dm_req_wmask,
    input  logic        dm_req_valid,
    output logic        dm_req_ready,
    output logic [63:0] dm_resp_rdata,
    output logic        dm_resp_valid,
    output logic [63:0] bus_req_addr,
    output logic        bus_req_wen,
    output logic [63:0] bus_req_wdata,
    output logic [7:0]  bus_req_wmask,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    input  logic [63:0] bus_resp_rdata,
`ifdef MEM_ARB_PERF_EN
    input  logic        bus_resp_valid,
    output logic [31:0] perf_im_grants,
    output logic [31:0] perf_dm_grants,
    output logic [31:0] perf_im_wait_cycles,
    output logic [31:0] perf_drops
`else
    input  logic        bus_resp_valid
`endif
);

    arb_state_t state;
    arb_state_t state_next;
    bus_req_t   bus_req;
    logic       owner;
    logic       drop;
    logic       idle;
    logic       grant_im;
    logic       grant_dm;
    logic       resp_fire;
    logic       im_resp_hit;
    logic       im_resp_drop;
    logic       busy_im;

    assign idle = (state == MEM_ARB_IDLE);

    mem_arb_pick #(
        .MAX_DM_STREAK(MAX_DM_STREAK)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .im_valid(im_req_valid),
        .dm_valid(dm_req_valid),
        .accept  (idle),
        .grant_im(grant_im),
        .grant_dm(grant_dm)
    );

    // Readies are held low while reset is asserted, even though state already reads IDLE.
    assign im_req_ready = rst && idle && grant_im;
    assign dm_req_ready = rst && idle && grant_dm;

    // Responses outside WAIT are protocol violations and never reach either port.
    assign resp_fire    = (state == MEM_ARB_WAIT) && bus_resp_valid;
    assign im_resp_hit  = resp_fire && (owner == MEM_OWN_IM);
    assign im_resp_drop = im_resp_hit && (drop || im_flush);

    assign im_resp_valid = im_resp_hit && !im_resp_drop;
    assign dm_resp_valid = resp_fire && (owner == MEM_OWN_DM);
    assign im_resp_rdata = bus_resp_rdata;
    assign dm_resp_rdata = bus_resp_rdata;

    assign bus_req_addr  = bus_req.addr;
    assign bus_req_wen   = bus_req.wen;
    assign bus_req_wdata = bus_req.wdata;
    assign bus_req_wmask = bus_req.wmask;

    assign busy_im = !idle && (owner == MEM_OWN_IM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MEM_ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MEM_ARB_IDLE: begin
                if (im_req_ready || dm_req_ready) begin
                    state_next = MEM_ARB_REQ;
                end
            end
            MEM_ARB_REQ: begin
                if (bus_req_ready) begin
                    state_next = MEM_ARB_WAIT;
                end
            end
            MEM_ARB_WAIT: begin
                if (bus_resp_valid) begin
                    state_next = MEM_ARB_IDLE;
                end
            end
            default: state_next = MEM_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req       <= '0;
            bus_req_valid <= 1'b0;
            owner         <= MEM_OWN_IM;
        end else if (dm_req_ready) begin
            bus_req       <= '{addr: dm_req_addr, wen: dm_req_wen,
                               wdata: dm_req_wdata, wmask: dm_req_wmask};
            bus_req_valid <= 1'b1;
            owner         <= MEM_OWN_DM;
        end else if (im_req_ready) begin
            bus_req       <= '{addr: im_req_addr, wen: 1'b0, wdata: 64'd0, wmask: 8'h00};
            bus_req_valid <= 1'b1;
            owner         <= MEM_OWN_IM;
        end else if ((state == MEM_ARB_REQ) && bus_req_ready) begin
            bus_req_valid <= 1'b0;
        end
    end

    // A flushed fetch still completes on the bus; its response is just swallowed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop <= 1'b0;
        end else if (resp_fire) begin
            drop <= 1'b0;
        end else if (busy_im && im_flush) begin
            drop <= 1'b1;
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_im_grants      <= '0;
            perf_dm_grants      <= '0;
            perf_im_wait_cycles <= '0;
            perf_drops          <= '0;
        end else begin
            if (im_req_ready) begin
                perf_im_grants <= perf_im_grants + 32'd1;
            end
            if (dm_req_ready) begin
                perf_dm_grants <= perf_dm_grants + 32'd1;
            end
            if (im_req_valid && !im_req_ready) begin
                perf_im_wait_cycles <= perf_im_wait_cycles + 32'd1;
            end
            if (im_resp_drop) begin
                perf_drops <= perf_drops + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed scoreboard bench for mem_arb.
module tb_mem_arb;

    localparam logic [63:0] IM_ADDR = 64'h0000_0000_8000_1000;
    localparam logic [63:0] DM_ADDR = 64'h0000_0000_0000_2040;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] im_req_addr;
    logic        im_req_valid;
    logic        im_req_ready;
    logic        im_flush;
    logic [63:0] im_resp_rdata;
    logic        im_resp_valid;
    logic [63:0] dm_req_addr;
    logic        dm_req_wen;
    logic [63:0] dm_req_wdata;
    logic [7:0]  dm_req_wmask;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [63:0] dm_resp_rdata;
    logic        dm_resp_valid;
    logic [63:0] bus_req_addr;
    logic        bus_req_wen;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_wmask;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [63:0] bus_resp_rdata;
    logic        bus_resp_valid;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_im_grants;
    logic [31:0] perf_dm_grants;
    logic [31:0] perf_im_wait_cycles;
    logic [31:0] perf_drops;
`endif

    typedef struct {
        bit          is_dm;
        bit          vis;
        logic [63:0] data;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arb #(.MAX_DM_STREAK(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .im_req_addr   (im_req_addr),
        .im_req_valid  (im_req_valid),
        .im_req_ready  (im_req_ready),
        .im_flush      (im_flush),
        .im_resp_rdata (im_resp_rdata),
        .im_resp_valid (im_resp_valid),
        .dm_req_addr   (dm_req_addr),
        .dm_req_wen    (dm_req_wen),
        .dm_req_wdata  (dm_req_wdata),
        .dm_req_wmask  (dm_req_wmask),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_resp_rdata (dm_resp_rdata),
        .dm_resp_valid (dm_resp_valid),
        .bus_req_addr  (bus_req_addr),
        .bus_req_wen   (bus_req_wen),
        .bus_req_wdata (bus_req_wdata),
        .bus_req_wmask (bus_req_wmask),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_resp_rdata(bus_resp_rdata),
`ifdef MEM_ARB_PERF_EN
        .bus_resp_valid(bus_resp_valid),
        .perf_im_grants(perf_im_grants),
        .perf_dm_grants(perf_dm_grants),
        .perf_im_wait_cycles(perf_im_wait_cycles),
        .perf_drops    (perf_drops)
`else
        .bus_resp_valid(bus_resp_valid)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge after a grant (arbiter in REQ); returns at the negedge back in IDLE.
    task automatic serve(input int stall, input logic [63:0] addr, input logic wen,
                         input logic [63:0] wdata, input logic [7:0] wmask,
                         input logic [63:0] rdata, input bit flush_wait, input bit flush_resp);
        exp_t e;
        for (int i = 0; i <= stall; i++) begin
            bus_req_ready = (i == stall);
            #1;
            chk("bus_req_valid_req", bus_req_valid, 1'b1);
            chk("bus_req_addr", bus_req_addr, addr);
            chk("bus_req_wdata", bus_req_wdata, wdata);
            chk("bus_req_wen_wmask", {bus_req_wen, bus_req_wmask}, {wen, wmask});
            chk("ready_busy", {im_req_ready, dm_req_ready}, 2'b00);
            @(negedge clk);
        end
        bus_req_ready = 1'b0;
        #1;
        chk("bus_req_valid_wait", bus_req_valid, 1'b0);
        if (flush_wait) begin
            im_flush = 1'b1;
            #1;
            chk("resp_quiet_flush", {im_resp_valid, dm_resp_valid}, 2'b00);
            @(negedge clk);
            im_flush = 1'b0;
        end
        bus_resp_valid = 1'b1;
        bus_resp_rdata = rdata;
        im_flush       = flush_resp;
        #1;
        chk("scoreboard_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("im_resp_valid", im_resp_valid, !e.is_dm && e.vis);
            chk("dm_resp_valid", dm_resp_valid, e.is_dm);
            if (e.vis && e.chk_data) begin
                chk("resp_rdata", e.is_dm ? dm_resp_rdata : im_resp_rdata, e.data);
            end
        end
        @(negedge clk);
        bus_resp_valid = 1'b0;
        im_flush       = 1'b0;
        #1;
        chk("resp_single_cycle", {im_resp_valid, dm_resp_valid}, 2'b00);
    endtask

    // Both requesters held valid; with a streak limit of 4 every fifth grant goes to IM.
    task automatic grant_run(input int n);
        for (int k = 0; k < n; k++) begin
            bit          exp_dm;
            logic [63:0] data;
            exp_dm = ((k % 5) != 4);
            data   = 64'hA5A5_0000_0000_0000 | 64'(k);
            #1;
            chk("grant_dm", dm_req_ready, exp_dm);
            chk("grant_im", im_req_ready, !exp_dm);
            exp_q.push_back('{exp_dm, 1'b1, data, 1'b1});
            @(negedge clk);
            if (exp_dm) serve(0, DM_ADDR, 1'b0, 64'd0, 8'hFF, data, 1'b0, 1'b0);
            else        serve(0, IM_ADDR, 1'b0, 64'd0, 8'h00, data, 1'b0, 1'b0);
        end
    endtask

    task automatic im_fetch(input logic [63:0] addr, input logic [63:0] data,
                            input bit vis, input bit flush_wait, input bit flush_resp);
        im_req_addr  = addr;
        im_req_valid = 1'b1;
        #1;
        chk("im_req_ready", im_req_ready, 1'b1);
        chk("dm_req_ready_idle", dm_req_ready, 1'b0);
        exp_q.push_back('{1'b0, vis, data, 1'b1});
        @(negedge clk);
        im_req_valid = 1'b0;
        serve(0, addr, 1'b0, 64'd0, 8'h00, data, flush_wait, flush_resp);
    endtask

    initial begin
        rst = 1'b0;
        im_req_addr = '0; im_req_valid = 1'b1; im_flush = 1'b0;
        dm_req_addr = '0; dm_req_wen = 1'b0; dm_req_wdata = '0; dm_req_wmask = '0;
        dm_req_valid = 1'b0; bus_req_ready = 1'b0; bus_resp_rdata = '0; bus_resp_valid = 1'b0;
        #2;
        chk("rst_bus_req_valid", bus_req_valid, 1'b0);
        chk("rst_bus_req_addr", bus_req_addr, 64'd0);
        chk("rst_bus_req_wdata", bus_req_wdata, 64'd0);
        chk("rst_bus_req_wen_wmask", {bus_req_wen, bus_req_wmask}, 9'd0);
        chk("rst_ready", {im_req_ready, dm_req_ready}, 2'b00);
        chk("rst_resp_valid", {im_resp_valid, dm_resp_valid}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        im_req_valid = 1'b0;

        // Lone fetch with immediate bus accept.
        im_fetch(64'h0000_0000_8000_0000, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b0);

        // Contention: DM x4, IM, DM x4, IM.
        im_req_addr  = IM_ADDR;
        dm_req_addr  = DM_ADDR;
        dm_req_wen   = 1'b0;
        dm_req_wdata = 64'd0;
        dm_req_wmask = 8'hFF;
        im_req_valid = 1'b1;
        dm_req_valid = 1'b1;
        grant_run(10);
        im_req_valid = 1'b0;
        dm_req_valid = 1'b0;

        // DM write stalled five cycles downstream.
        dm_req_addr  = 64'h100;
        dm_req_wen   = 1'b1;
        dm_req_wdata = 64'hDEAD_BEEF;
        dm_req_wmask = 8'h0F;
        dm_req_valid = 1'b1;
        #1;
        chk("dm_wr_ready", dm_req_ready, 1'b1);
        chk("dm_wr_im_ready", im_req_ready, 1'b0);
        exp_q.push_back('{1'b1, 1'b1, 64'd0, 1'b0});
        @(negedge clk);
        dm_req_valid = 1'b0;
        serve(5, 64'h100, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'h0, 1'b0, 1'b0);

        // Flush while waiting, then a normal fetch.
        im_fetch(64'h4000, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0, 1'b1, 1'b0);
        im_fetch(64'h4008, 64'hC0DE_C0DE_0000_0001, 1'b1, 1'b0, 1'b0);

        // Flush coinciding with the response: IM suppressed, DM unaffected.
        im_fetch(64'h4010, 64'h0BAD_0000_0000_0002, 1'b0, 1'b0, 1'b1);
        dm_req_addr  = 64'h200;
        dm_req_wen   = 1'b0;
        dm_req_wdata = 64'd0;
        dm_req_wmask = 8'hFF;
        dm_req_valid = 1'b1;
        #1;
        chk("dm_rd_ready", dm_req_ready, 1'b1);
        exp_q.push_back('{1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1});
        @(negedge clk);
        dm_req_valid = 1'b0;
        serve(0, 64'h200, 1'b0, 64'd0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);

        // Flush in IDLE alongside a new fetch does not drop it.
        im_flush = 1'b1;
        im_req_addr  = 64'h5000;
        im_req_valid = 1'b1;
        #1;
        chk("flush_idle_ready", im_req_ready, 1'b1);
        exp_q.push_back('{1'b0, 1'b1, 64'h5555_AAAA_5555_AAAA, 1'b1});
        @(negedge clk);
        im_flush     = 1'b0;
        im_req_valid = 1'b0;
        serve(0, 64'h5000, 1'b0, 64'd0, 8'h00, 64'h5555_AAAA_5555_AAAA, 1'b0, 1'b0);

        // Stray response in IDLE is ignored.
        bus_resp_valid = 1'b1;
        bus_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("stray_resp", {im_resp_valid, dm_resp_valid}, 2'b00);
        @(negedge clk);
        bus_resp_valid = 1'b0;
        #1;
        chk("stray_no_req", bus_req_valid, 1'b0);

        // Reset in REQ with a partial streak; afterwards the streak restarts from 0.
        im_req_addr  = IM_ADDR;
        dm_req_addr  = DM_ADDR;
        dm_req_wmask = 8'hFF;
        im_req_valid = 1'b1;
        dm_req_valid = 1'b1;
        grant_run(2);
        #1;
        chk("pre_rst_dm_grant", dm_req_ready, 1'b1);
        @(negedge clk);
        #1;
        chk("pre_rst_bus_valid", bus_req_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("async_rst_bus_valid", bus_req_valid, 1'b0);
        chk("async_rst_ready", {im_req_ready, dm_req_ready}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        grant_run(5);
        im_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Shares one downstream memory bus between the instruction-fetch port and the data-memory port.
- Sits between the fetch pipeline, the LSU and the memory/cache interconnect.
- Non-pipelined: one bus transaction in flight at a time.
- Fixed data-side priority, with an anti-starvation streak limit for fetch.
- On PC redirect, discards the in-flight fetch response.

Parameters:
- MAX_DM_STREAK, 4: consecutive DM grants allowed while IM is waiting before IM is forced a grant (legal range 1..15).

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- im_req_addr  in  64  fetch address
- im_req_valid  in  1  fetch request
- im_req_ready  out  1  fetch request accepted this cycle
- im_flush  in  1  PC-override pulse; drop any in-flight fetch response
- im_resp_rdata  out  64  fetch read data
- im_resp_valid  out  1  fetch response strobe
- dm_req_addr  in  64  data address
- dm_req_wen  in  1  1 = write
- dm_req_wdata  in  64  write data
- dm_req_wmask  in  8  byte enables
- dm_req_valid  in  1  data request
- dm_req_ready  out  1  data request accepted
- dm_resp_rdata  out  64  read data (undefined for writes)
- dm_resp_valid  out  1  read data or write ack strobe
- bus_req_addr  out  64  registered address
- bus_req_wen  out  1  registered write enable
- bus_req_wdata  out  64  registered write data
- bus_req_wmask  out  8  registered byte mask (IM grants drive 8'h00)
- bus_req_valid  out  1  registered request valid
- bus_req_ready  in  1  downstream accepts request
- bus_resp_rdata  in  64  downstream data
- bus_resp_valid  in  1  downstream response, one per accepted request

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=IM, drop=0, streak=0.
  - bus_req_valid=0; bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_wen=0.
  - All ready and resp_valid outputs=0.
- Reset mid-transaction abandons it with no response. Downstream must be reset together.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Pick combinationally:
    - only one valid → that requester;
    - both valid → DM, unless streak==MAX_DM_STREAK, then IM.
  - Winner's req_ready=1 in the same cycle; the other ready=0. Both ready=0 outside IDLE.
  - On handshake, latch addr/wen/wdata/wmask into the bus_req_* registers, set bus_req_valid=1, record owner, go to REQ.
  - bus_req_valid rises the cycle after acceptance.
- Streak counter:
  - DM grant while im_req_valid=1: streak+1, saturating.
  - DM grant while im_req_valid=0: clear to 0.
  - Any IM grant: clear to 0.
- REQ:
  - Hold all bus_req_* stable until bus_req_ready=1.
  - Then clear bus_req_valid next edge and go to WAIT.
- WAIT:
  - On bus_resp_valid, route the response combinationally in the same cycle to the owner: rdata passthrough, resp_valid=1 for that port.
  - If owner=IM and (drop=1 or im_flush=1 this cycle), suppress im_resp_valid.
  - Return to IDLE and clear drop. A new grant is possible on the next cycle, so the minimum turnaround is 3 cycles per transaction.
- bus_resp_valid outside WAIT is a protocol violation: ignored and never forwarded.
- Flush:
  - im_flush in REQ or WAIT with owner=IM sets drop. The bus transaction still completes; the response is consumed silently.
  - im_flush with owner=DM, or in IDLE, has no effect.
  - A flush in IDLE does not block an im_req accepted in the same cycle.
- resp_valid outputs are never asserted simultaneously. dm_resp_valid is asserted for writes too (ack).

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- With the macro defined:
  - Adds outputs perf_im_grants[31:0], perf_dm_grants[31:0], perf_im_wait_cycles[31:0], perf_drops[31:0].
  - All are wrapping counters, reset to 0.
  - perf_im_wait_cycles increments each cycle im_req_valid=1 and im_req_ready=0.
  - perf_drops increments per suppressed fetch response.
- Without the macro: the ports and counters are absent, with identical functional behaviour.

Decomposition:
- defines.vh gains:
  - MEM_ARB_IDLE, MEM_ARB_REQ, MEM_ARB_WAIT (2-bit encodings);
  - MEM_OWN_IM=1'b0, MEM_OWN_DM=1'b1.
- One sub-module, mem_arb_pick: combinational grant select plus the streak counter register, with inputs im_valid, dm_valid, accept; outputs grant_im, grant_dm.
- FSM and bus registers stay in mem_arb.

Test Plan:
- IM read 0x80000000 alone, bus_req_ready immediate, resp 2 cycles later with rdata 0x1122334455667788 → im_req_ready same cycle as valid; bus_req_valid next cycle; im_resp_valid one cycle with that data; dm_resp_valid stays 0.
- Both valid continuously, MAX_DM_STREAK=4 → grant order DM,DM,DM,DM,IM,DM,DM,DM,DM,IM.
- DM write addr 0x100, wdata 0xDEADBEEF, wmask 0x0F, bus_req_ready held 0 for 5 cycles → bus_req_* stable all 5 cycles; single dm_resp_valid after response.
- IM fetch in flight, im_flush pulse in WAIT before the response → response consumed, im_resp_valid never 1; the next IM request is granted normally.
- im_flush in the same cycle as bus_resp_valid for an IM transaction → im_resp_valid=0. Same pulse during a DM transaction → dm_resp_valid=1 unaffected.
- rst driven 0 while in REQ → bus_req_valid drops immediately (asynchronous), state IDLE; after release, first request is serviced with streak=0.
